// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and helpers for the clk_div_bank block:
//               lock FSM state encoding and the phase clamp function.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    APPLY  = 2'd2
  } lock_state_t;

  // Fixed working width of the clamp helper; callers size-cast in and out.
  localparam int CLAMP_W = 32;

  // A phase at or beyond the divide ratio could never match the counter,
  // so it is stored as the last cycle of the period instead.
  function automatic logic [CLAMP_W-1:0] clamp_phase(
    input logic [CLAMP_W-1:0] phase,
    input logic [CLAMP_W-1:0] div
  );
    logic [CLAMP_W-1:0] res;
    res = phase;
    if (div == '0) begin
      res = '0;
    end else if (phase >= div) begin
      res = div - 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel: divide ratio, phase and period counter
//               registers plus the registered enable / square-wave outputs.
// Ports       : clk, rst          - clock, async active-high reset
//               clr_i             - restart the period counter at 0
//               wr_i              - load wr_div_i / wr_phase_i
//               wr_div_i          - new divide ratio (0 disables channel)
//               wr_phase_i        - new phase (clamped on write)
//               lock_next_i       - lock value that becomes visible next cycle
//               clk_en_o          - one-cycle pulse per period
//               clk_out_o         - divided square wave
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  input  logic [DIV_W-1:0] wr_phase_i,
  input  logic             lock_next_i,
  output logic             clk_en_o,
  output logic             clk_out_o
);

  logic [DIV_W-1:0] div_q,   div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q,   cnt_d;
  logic             en_d,    out_d;
  logic [DIV_W:0]   half;

  // High time is ceil(div/2) so odd ratios get the extra cycle high.
  assign half = ({1'b0, div_q} + 1'b1) >> 1;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (wr_i) begin
      div_d   = wr_div_i;
      phase_d = DIV_W'(clamp_phase(CLAMP_W'(wr_phase_i), CLAMP_W'(wr_div_i)));
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (div_q == '0) || (cnt_q >= div_q - 1'b1)) begin
      cnt_d = '0;
    end
  end

  // Outputs follow the current counter and are gated by next-cycle lock,
  // so they drop together with lock and never rise before it.
  always_comb begin
    en_d  = lock_next_i && (div_q != '0) && (cnt_q == phase_q);
    out_d = lock_next_i && (div_q != '0) && ({1'b0, cnt_q} < half);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= DIV_W'(DEFAULT_DIV);
      phase_q   <= '0;
      cnt_q     <= '0;
      clk_en_o  <= 1'b0;
      clk_out_o <= 1'b0;
    end else begin
      div_q     <= div_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      clk_en_o  <= en_d;
      clk_out_o <= out_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : Multi-channel clock-enable generator with runtime
//               reprogrammable divide ratio / phase and emulated PLL lock.
// Ports       : clk, rst          - clock, async active-high reset
//               cfg_valid_i       - config request
//               cfg_ready_o       - config accepted this cycle if valid
//               cfg_ch_i          - target channel
//               cfg_div_i         - divide ratio (0 disables channel)
//               cfg_phase_i       - cycle within period for clk_en pulse
//               lock_o            - outputs valid and stable
//               clk_en_o          - per-channel one-cycle enable pulses
//               clk_out_o         - per-channel divided square waves
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_valid_i,
  output logic                                          cfg_ready_o,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch_i,
  input  logic [DIV_W-1:0]                              cfg_div_i,
  input  logic [DIV_W-1:0]                              cfg_phase_i,
  output logic                                          lock_o,
  output logic [CHANNELS-1:0]                           clk_en_o,
  output logic [CHANNELS-1:0]                           clk_out_o
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  lock_state_t      state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             accept;
  logic             apply;
  logic             lock_next;

  assign cfg_ready_o = (state_q != APPLY);
  assign accept      = cfg_valid_i && cfg_ready_o;
  // Out-of-range channel requests are handshaken but otherwise ignored.
  assign apply       = accept && (32'(cfg_ch_i) < CHANNELS);
  assign lock_o      = (state_q == LOCKED);
  assign lock_next   = (state_d == LOCKED);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      SETTLE: begin
        if (apply) begin
          state_d  = APPLY;
          settle_d = '0;
        end else if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
          state_d  = LOCKED;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      LOCKED: begin
        if (apply) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      default: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Every accepted write clears all counters so channels stay phase aligned.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic wr;
    assign wr = apply && (cfg_ch_i == CH_W'(g));

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (apply),
      .wr_i        (wr),
      .wr_div_i    (cfg_div_i),
      .wr_phase_i  (cfg_phase_i),
      .lock_next_i (lock_next),
      .clk_en_o    (clk_en_o[g]),
      .clk_out_o   (clk_out_o[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Self-checking bench for clk_div_bank (4-channel instance plus
//               a 3-channel instance for the out-of-range channel case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       rst;
  // 4-channel instance
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_phase;
  logic       lock;
  logic [3:0] clk_en;
  logic [3:0] clk_out;
  // 3-channel instance
  logic       v3;
  logic       rdy3;
  logic [1:0] ch3;
  logic [7:0] div3;
  logic [7:0] ph3;
  logic       lock3;
  logic [2:0] en3;
  logic [2:0] out3;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  always #5 clk = ~clk;

  clk_div_bank #(
    .CHANNELS(4), .DIV_W(8), .DEFAULT_DIV(2), .LOCK_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div), .cfg_phase_i(cfg_phase),
    .lock_o(lock), .clk_en_o(clk_en), .clk_out_o(clk_out)
  );

  clk_div_bank #(
    .CHANNELS(3), .DIV_W(8), .DEFAULT_DIV(2), .LOCK_CYCLES(16)
  ) dut3 (
    .clk(clk), .rst(rst),
    .cfg_valid_i(v3), .cfg_ready_o(rdy3),
    .cfg_ch_i(ch3), .cfg_div_i(div3), .cfg_phase_i(ph3),
    .lock_o(lock3), .clk_en_o(en3), .clk_out_o(out3)
  );

  typedef struct {
    int         cyc;
    logic       v;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [7:0] ph;
    logic       lk;
    logic       rdy;
    logic [3:0] en;
    logic [3:0] out;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int c, input logic v, input logic [1:0] ch,
                     input logic [7:0] dv, input logic [7:0] ph,
                     input logic lk, input logic rdy,
                     input logic [3:0] en, input logic [3:0] out);
    vec_t e;
    e.cyc = c; e.v = v; e.ch = ch; e.dv = dv; e.ph = ph;
    e.lk = lk; e.rdy = rdy; e.en = en; e.out = out;
    vecs.push_back(e);
  endtask

  task automatic chk(input string nm, input int cy,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, cy, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", k);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ex;

    // Edge numbers count from reset release; a vector with v=1 is presented
    // during the cycle that ends at edge cyc and checked just after it.
    //   cyc  v  ch    div   phase  lock rdy  en     out
    add(15, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(16, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h0, 4'h0);
    add(17, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'hF, 4'hF);
    add(18, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h0, 4'h0);
    add(19, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'hF, 4'hF);
    // ch1 div=5 phase=3
    add(20, 1, 2'd1, 8'd5, 8'd3,   0,   0,   4'h0, 4'h0);
    add(21, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(36, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(37, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'hD, 4'hF);
    add(38, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h0, 4'h2);
    add(39, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'hF, 4'hD);
    add(40, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h0, 4'h0);
    add(41, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'hD, 4'hF);
    add(42, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h0, 4'h2);
    add(43, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'hD, 4'hF);
    add(44, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h2, 4'h0);
    // ch2 div=4 phase=9 (clamps to 3), then ch3 div=0 during settle
    add(50, 1, 2'd2, 8'd4, 8'd9,   0,   0,   4'h0, 4'h0);
    add(51, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(52, 1, 2'd3, 8'd0, 8'd0,   0,   0,   4'h0, 4'h0);
    add(53, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(68, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(69, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h1, 4'h7);
    add(70, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h0, 4'h6);
    add(71, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h3, 4'h1);
    add(72, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h4, 4'h0);
    add(73, 0, 2'd0, 8'd0, 8'd0,   1,   1,   4'h1, 4'h7);
    // ch0 div=3, then ch1 div=6 at settle cycle 11 restarts settling
    add(80, 1, 2'd0, 8'd3, 8'd0,   0,   0,   4'h0, 4'h0);
    add(81, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(91, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(92, 1, 2'd1, 8'd6, 8'd0,   0,   0,   4'h0, 4'h0);
    add(93, 0, 2'd0, 8'd0, 8'd0,   0,   1,   4'h0, 4'h0);
    add(108, 0, 2'd0, 8'd0, 8'd0,  0,   1,   4'h0, 4'h0);
    add(109, 0, 2'd0, 8'd0, 8'd0,  1,   1,   4'h0, 4'h5);
    add(110, 0, 2'd0, 8'd0, 8'd0,  1,   1,   4'h0, 4'h4);
    add(111, 0, 2'd0, 8'd0, 8'd0,  1,   1,   4'h3, 4'h3);
    add(112, 0, 2'd0, 8'd0, 8'd0,  1,   1,   4'h4, 4'h3);
    add(113, 0, 2'd0, 8'd0, 8'd0,  1,   1,   4'h0, 4'h6);
    add(114, 0, 2'd0, 8'd0, 8'd0,  1,   1,   4'h1, 4'h5);

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
    v3 = 1'b0; ch3 = '0; div3 = '0; ph3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset lock",   0, 32'(lock), 32'd0);
    chk("reset ready",  0, 32'(cfg_ready), 32'd1);
    chk("reset clk_en", 0, 32'(clk_en), 32'd0);
    chk("reset clk_out",0, 32'(clk_out), 32'd0);
    rst = 1'b0;
    k = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      while (k < vecs[i].cyc - 1) tick();
      cfg_valid = vecs[i].v;
      cfg_ch    = vecs[i].ch;
      cfg_div   = vecs[i].dv;
      cfg_phase = vecs[i].ph;
      tick();
      cfg_valid = 1'b0;
      chk("vec lock",    k, 32'(lock),      32'(vecs[i].lk));
      chk("vec ready",   k, 32'(cfg_ready), 32'(vecs[i].rdy));
      chk("vec clk_en",  k, 32'(clk_en),    32'(vecs[i].en));
      chk("vec clk_out", k, 32'(clk_out),   32'(vecs[i].out));
    end

    // Asynchronous reset in the middle of a locked period.
    repeat (3) tick();
    chk("pre-reset lock", k, 32'(lock), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst lock",    k, 32'(lock),      32'd0);
    chk("async rst ready",   k, 32'(cfg_ready), 32'd1);
    chk("async rst clk_en",  k, 32'(clk_en),    32'd0);
    chk("async rst clk_out", k, 32'(clk_out),   32'd0);
    chk("async rst lock3",   k, 32'(lock3),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;

    // Relock with every channel back at the default ratio of 2.
    for (int j = 1; j <= 19; j++) begin
      tick();
      ex = ((j >= 17) && (j % 2 == 1)) ? 4'hF : 4'h0;
      chk("relock lock",    k, 32'(lock),    32'(j >= 16));
      chk("relock clk_en",  k, 32'(clk_en),  32'(ex));
      chk("relock clk_out", k, 32'(clk_out), 32'(ex));
      chk("relock lock3",   k, 32'(lock3),   32'(j >= 16));
    end

    // Out-of-range channel on the 3-channel instance: consumed, no effect.
    v3 = 1'b1; ch3 = 2'd3; div3 = 8'd0; ph3 = 8'd0;
    chk("oor ready before", k, 32'(rdy3), 32'd1);
    tick();
    v3 = 1'b0;
    chk("oor lock3",  k, 32'(lock3), 32'd1);
    chk("oor ready3", k, 32'(rdy3),  32'd1);
    chk("oor en3",    k, 32'(en3),   32'd0);
    tick();
    chk("oor lock3 next", k, 32'(lock3), 32'd1);
    chk("oor en3 next",   k, 32'(en3),   32'h7);
    chk("oor out3 next",  k, 32'(out3),  32'h7);
    tick();
    chk("oor en3 after",  k, 32'(en3),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock-enable generator. It derives up to CHANNELS divided clock enables and square waves from the single PLL output clock. Each channel has a divide ratio and phase offset that can be reprogrammed at runtime through a valid/ready port. A lock indication emulates PLL lock behaviour, so downstream logic (LED scanners, UART baud ticks) can run at several rates from one clock domain.

## Interface
Parameters:
- CHANNELS, 4: number of output channels (1..16)
- DIV_W, 8: width of divide ratio and phase fields
- DEFAULT_DIV, 2: divide ratio loaded into every channel at reset
- LOCK_CYCLES, 16: settle length in clk cycles before lock asserts (≥1)

Ports:
- clk  in  1  system clock (PLL clkout); all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted this cycle
- cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel
- cfg_div  in  DIV_W  new divide ratio; 0 disables the channel
- cfg_phase  in  DIV_W  cycle within period at which clk_en pulses
- lock  out  1  outputs valid and stable
- clk_en  out  CHANNELS  one-cycle enable pulse per period, per channel
- clk_out  out  CHANNELS  divided square wave, per channel

## Operation
- Per channel i:
  - Registers div[i], phase[i], and cnt[i] (all DIV_W).
  - cnt counts 0..div-1 and then wraps to 0.
  - If div=0, cnt is held at 0 and both outputs are 0.
- Phase clamp: if phase ≥ div, the stored value is used as div-1. Clamping happens at write time.
- Output flops, each updated from the registered cnt:
  - clk_en[i] <= lock_next & (div≠0) & (cnt==phase).
  - clk_out[i] <= lock_next & (div≠0) & (cnt < (div+1)>>1).
  - For div=1, clk_out is constant 1 and clk_en is constant 1 while locked.
  - For odd div, the high time is one cycle longer than the low time.
- Outputs are forced 0 whenever lock is (or becomes) 0.
- Lock FSM states: SETTLE, LOCKED, APPLY.
  - Reset enters SETTLE with settle_cnt=0.
  - SETTLE: settle_cnt increments each cycle. When it reaches LOCKED_CYCLES-1, the next state is LOCKED.
  - LOCKED: remains until a config is accepted.
  - APPLY: lasts one cycle, then goes to SETTLE with settle_cnt=0.
- Acceptance: cfg_valid & cfg_ready on a rising edge.
  - cfg_ready=1 in SETTLE and LOCKED, and 0 in APPLY.
- On acceptance with cfg_ch < CHANNELS:
  - div[cfg_ch] and phase[cfg_ch] are written.
  - cnt of all channels is cleared to 0, which keeps inter-channel phase alignment.
  - The FSM goes to APPLY and lock drops.
- On acceptance with cfg_ch ≥ CHANNELS: the request is consumed and dropped. There is no register write, no counter clear and no FSM change.
- An acceptance during SETTLE restarts the settle sequence.
- Reset values:
  - div=DEFAULT_DIV, phase=0, cnt=0.
  - lock=0, cfg_ready=1, clk_en=0, clk_out=0.

## Timing
- Reset, with rst deasserted before edge E1: lock=1 after edge E(LOCK_CYCLES).
- Config accepted at edge A:
  - After A: APPLY, lock=0, cfg_ready=0, counters=0.
  - After A+1: SETTLE, and counters run from 0.
  - After A+1+LOCK_CYCLES: lock=1.
- Output latency: clk_en/clk_out reflect the cnt value of the previous cycle (one flop stage).
- Outputs rise no earlier than the edge at which lock rises.
- Wrap rule: cnt==div-1 is followed by cnt=0 on the next edge. There is no skipped or doubled cycle across the wrap.
- Asynchronous rst mid-operation forces all reset values immediately. Pending config is lost.

## Structure
- clk_div_pkg holds:
  - lock_state_t enum (SETTLE, LOCKED, APPLY).
  - A phase clamp function (phase, div) returning the clamped phase.
- Sub-module clk_div_chan holds one channel's div/phase/cnt registers and output flops.
  - Inputs: clr, wr, wr_div, wr_phase, lock_next.
  - It is instantiated CHANNELS times with generate.
- The top level holds the FSM, settle counter and cfg decode.

## Test plan
CHANNELS=4, DIV_W=8, LOCK_CYCLES=16.
- Reset release → lock=1 exactly 16 edges later; clk_out[0..3] toggle every cycle pair (div=2); clk_en period is 2.
- Write ch1 div=5 phase=3 → cfg_ready=0 for 1 cycle, lock low 17 cycles; then clk_en[1] pulses every 5 cycles at cnt==3; clk_out[1] is high 3, low 2.
- Write ch2 div=4 phase=9 → phase clamped to 3; clk_en[2] pulses at cnt==3; write ch3 div=0 → clk_en[3]=clk_out[3]=0 permanently.
- Write ch0 div=3, then a second write at SETTLE cycle 10 → settle restarts; lock rises 17 cycles after the second acceptance; ch0 and ch1 clk_en remain aligned to cnt=0 restart.
- cfg_ch=5 (out of range, 3-bit field not applicable; use CHANNELS=4 with a 2-bit field and force via CHANNELS=3, cfg_ch=3) → accepted, lock stays 1, outputs unchanged.
- Assert rst mid-period while locked → all outputs 0 and div=2 immediately; relock after 16 edges.
